// File: rtl/map_tile_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : map_tile_reader
// Description : Turns VGA pixel timing into tile-map RAM addresses and returns
//               the tile under each pixel, aligned with the delayed timing.
// Revision    : 1.0 - initial release
// ============================================================================
module map_tile_reader #(
    parameter int TILE_SIZE = 16,
    parameter int MAP_W     = 40,
    parameter int MAP_H     = 30,
    parameter int ADDR_W    = 11,
    parameter int TILE_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       vga_hcount_i,
    input  logic [10:0]       vga_vcount_i,
    input  logic              vga_hblnk_i,
    input  logic              vga_vblnk_i,
    input  logic              vga_hsync_i,
    input  logic              vga_vsync_i,
    output logic [ADDR_W-1:0] map_addr_o,
    input  logic [TILE_W-1:0] map_data_i,
    output logic [TILE_W-1:0] act_tile_o,
    output logic [10:0]       vga_hcount_o,
    output logic [10:0]       vga_vcount_o,
    output logic              vga_hblnk_o,
    output logic              vga_vblnk_o,
    output logic              vga_hsync_o,
    output logic              vga_vsync_o
);

    localparam int c_ACT_W = MAP_W * TILE_SIZE;
    localparam int c_ACT_H = MAP_H * TILE_SIZE;
    localparam int c_PX_W  = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int c_COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int c_ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int c_TIM_W = 26;

    localparam logic [c_PX_W-1:0]  c_PX_LAST  = c_PX_W'(TILE_SIZE - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(MAP_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(MAP_H - 1);
    localparam logic [TILE_W-1:0]  c_EMPTY    = '0;

    logic [c_PX_W-1:0]  px_x_q, px_x_d, px_y_q, px_y_d;
    logic [c_COL_W-1:0] col_q, col_d;
    logic [c_ROW_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  map_addr_q, map_addr_d;
    logic               act1_q, act1_d;
    logic [TILE_W-1:0]  tile_q, tile_d;
    logic [c_TIM_W-1:0] tim1_q, tim2_q, w_tim;

    logic w_line_start, w_line_end, w_h_act, w_v_act;

    assign w_line_start = (vga_hcount_i == 11'd0);
    assign w_line_end   = (vga_hcount_i == 11'(c_ACT_W));
    assign w_h_act      = (vga_hcount_i < 11'(c_ACT_W));
    assign w_v_act      = (vga_vcount_i < 11'(c_ACT_H));
    assign w_tim        = {vga_hcount_i, vga_vcount_i, vga_hblnk_i, vga_vblnk_i,
                           vga_hsync_i, vga_vsync_i};

    always_comb begin
        px_x_d     = px_x_q;
        col_d      = col_q;
        px_y_d     = px_y_q;
        row_d      = row_q;
        row_base_d = row_base_q;

        if (w_line_start) begin
            px_x_d = '0;
            col_d  = '0;
        end else if (w_h_act) begin
            if (px_x_q == c_PX_LAST) begin
                px_x_d = '0;
                if (col_q != c_COL_LAST)
                    col_d = col_q + c_COL_W'(1);
            end else begin
                px_x_d = px_x_q + c_PX_W'(1);
            end
        end

        // Frame restart wins over the line advance; the last row holds through vertical blank.
        if (w_line_start && vga_vcount_i == 11'd0) begin
            px_y_d     = '0;
            row_d      = '0;
            row_base_d = '0;
        end else if (w_line_end && w_v_act) begin
            if (px_y_q == c_PX_LAST) begin
                px_y_d = '0;
                if (row_q != c_ROW_LAST) begin
                    row_d      = row_q + c_ROW_W'(1);
                    row_base_d = row_base_q + ADDR_W'(MAP_W);
                end
            end else begin
                px_y_d = px_y_q + c_PX_W'(1);
            end
        end

        map_addr_d = row_base_d + ADDR_W'(col_d);
        act1_d     = w_h_act && w_v_act;
        tile_d     = act1_q ? map_data_i : c_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_x_q     <= '0;
            col_q      <= '0;
            px_y_q     <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            map_addr_q <= '0;
            act1_q     <= 1'b0;
            tile_q     <= c_EMPTY;
            tim1_q     <= '0;
            tim2_q     <= '0;
        end else begin
            px_x_q     <= px_x_d;
            col_q      <= col_d;
            px_y_q     <= px_y_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            map_addr_q <= map_addr_d;
            act1_q     <= act1_d;
            tile_q     <= tile_d;
            tim1_q     <= w_tim;
            tim2_q     <= tim1_q;
        end
    end

    assign map_addr_o = map_addr_q;
    assign act_tile_o = tile_q;
    assign {vga_hcount_o, vga_vcount_o, vga_hblnk_o, vga_vblnk_o,
            vga_hsync_o, vga_vsync_o} = tim2_q;

endmodule
`default_nettype wire

// File: tb/tb_map_tile_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_map_tile_reader
// Description : Scoreboard bench for map_tile_reader with a tile-RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_tile_reader;

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] WALL   = 2'd1;
    localparam logic [1:0] SNAKE1 = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hc_i = '0, vc_i = '0;
    logic        hb_i = 1'b0, vb_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [10:0] map_addr;
    logic [1:0]  map_data, act_tile;
    logic [10:0] hc_o, vc_o;
    logic        hb_o, vb_o, hs_o, vs_o;

    logic [1:0]  mem [0:2047];
    bit          rand_sync = 1'b0;
    int          errors = 0;
    int          checks = 0;

    typedef struct { logic [10:0] addr; bit chk; } a_t;
    typedef struct { logic [10:0] h; logic [10:0] v; logic [3:0] sy; logic [1:0] tile; } o_t;
    a_t aq[$];
    o_t oq[$];

    always #5 clk = ~clk;

    // Tile RAM whose read port is addressed by the registered map_addr.
    assign map_data = mem[map_addr];

    map_tile_reader dut (
        .clk(clk), .rst_n(rst_n),
        .vga_hcount_i(hc_i), .vga_vcount_i(vc_i),
        .vga_hblnk_i(hb_i), .vga_vblnk_i(vb_i),
        .vga_hsync_i(hs_i), .vga_vsync_i(vs_i),
        .map_addr_o(map_addr), .map_data_i(map_data), .act_tile_o(act_tile),
        .vga_hcount_o(hc_o), .vga_vcount_o(vc_o),
        .vga_hblnk_o(hb_o), .vga_vblnk_o(vb_o),
        .vga_hsync_o(hs_o), .vga_vsync_o(vs_o)
    );

    // One pixel clock: compare what is due, then drive the next pixel and queue its expectations.
    task automatic step(input int h, input int v, input bit chk_empty);
        a_t a;
        o_t o;
        int addr;
        bit act;
        @(negedge clk);
        if (chk_empty) begin
            checks++;
            if (act_tile !== EMPTY) begin
                errors++;
                $display("FAIL post_reset_empty: act_tile=%0d expected=%0d", act_tile, EMPTY);
            end
        end
        if (aq.size() >= 1) begin
            a = aq.pop_front();
            if (a.chk) begin
                checks++;
                if (map_addr !== a.addr) begin
                    errors++;
                    $display("FAIL map_addr: got=%0d expected=%0d (t=%0t)", map_addr, a.addr, $time);
                end
            end
        end
        if (oq.size() >= 2) begin
            o = oq.pop_front();
            checks++;
            if ({hc_o, vc_o, hs_o, vs_o, hb_o, vb_o} !== {o.h, o.v, o.sy}) begin
                errors++;
                $display("FAIL vga_out: got h=%0d v=%0d sy=%b expected h=%0d v=%0d sy=%b",
                         hc_o, vc_o, {hs_o, vs_o, hb_o, vb_o}, o.h, o.v, o.sy);
            end
            checks++;
            if (act_tile !== o.tile) begin
                errors++;
                $display("FAIL act_tile: got=%0d expected=%0d at h=%0d v=%0d", act_tile, o.tile, o.h, o.v);
            end
        end
        hc_i = 11'(h);
        vc_i = 11'(v);
        hb_i = (h >= 640);
        vb_i = (v >= 480);
        hs_i = rand_sync ? 1'($urandom_range(0, 1)) : (h >= 656 && h < 752);
        vs_i = rand_sync ? 1'($urandom_range(0, 1)) : (v >= 490 && v < 492);
        act  = (h < 640) && (v < 480);
        addr = (v / 16) * 40 + (h / 16);
        aq.push_back('{11'(addr), act});
        oq.push_back('{11'(h), 11'(v), {hs_i, vs_i, hb_i, vb_i}, act ? mem[addr] : EMPTY});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(700, 500, 1'b0);
    endtask

    task automatic scan_line(input int v, input int last_h, input bit post_reset);
        for (int h = 0; h <= last_h; h++) step(h, v, post_reset && v == 0 && h < 2);
        step(640, v, 1'b0);
        step(700, v, 1'b0);
    endtask

    // Full lines where tile boundaries matter, short lines elsewhere to keep frames cheap.
    task automatic scan_frame(input bit post_reset);
        for (int v = 0; v < 480; v++)
            scan_line(v, (v == 0 || v == 15 || v == 16 || v == 479) ? 639 : 17, post_reset);
        for (int v = 480; v < 483; v++) scan_line(v, 1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (map_addr !== 11'd0) begin
            errors++;
            $display("FAIL %s map_addr: got=%0d expected=0", tag, map_addr);
        end
        checks++;
        if (act_tile !== EMPTY) begin
            errors++;
            $display("FAIL %s act_tile: got=%0d expected=%0d", tag, act_tile, EMPTY);
        end
        checks++;
        if ({hc_o, vc_o, hs_o, vs_o, hb_o, vb_o} !== 26'd0) begin
            errors++;
            $display("FAIL %s vga_out: got h=%0d v=%0d sy=%b expected all 0",
                     tag, hc_o, vc_o, {hs_o, vs_o, hb_o, vb_o});
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2048; i++) mem[i] = SNAKE1;
        hc_i = 11'd5; vc_i = 11'd7; hs_i = 1'b1; vs_i = 1'b1; hb_i = 1'b1; vb_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_frame_start_wall();
        for (int i = 0; i < 2048; i++) mem[i] = EMPTY;
        mem[5] = WALL;
        scan_frame(1'b0);
        idle(3);
    endtask

    task automatic test_two_frames();
        for (int i = 0; i < 2048; i++) mem[i] = 2'($urandom_range(0, 3));
        scan_frame(1'b0);
        scan_frame(1'b0);
        idle(3);
    endtask

    task automatic test_blanking();
        for (int i = 0; i < 2048; i++) mem[i] = SNAKE1;
        rand_sync = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(700, $urandom_range(0, 479), 1'b0);
            step($urandom_range(1, 639), 500, 1'b0);
            step(700, 500, 1'b0);
        end
        rand_sync = 1'b0;
        idle(3);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 2048; i++) mem[i] = SNAKE1;
        for (int v = 0; v < 200; v++) scan_line(v, 17, 1'b0);
        for (int h = 0; h <= 300; h++) step(h, 200, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        aq.delete();
        oq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        scan_frame(1'b1);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_frame_start_wall();
        test_two_frames();
        test_blanking();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/map_tile_reader.md
MAP_TILE_READER -- requirements
Module: map_tile_reader

Interface
REQ-001 Parameter TILE_SIZE, default 16: pixel edge of one square tile.
REQ-002 Parameter MAP_W, default 40: tiles per map row (640/16).
REQ-003 Parameter MAP_H, default 30: tile rows per map (480/16).
REQ-004 Parameter ADDR_W, default 11: map address width; SHALL satisfy 2**ADDR_W >= MAP_W*MAP_H.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts on clk.
REQ-007 vga_in  vga_if.in  -  timing from the VGA timing generator: hcount[10:0], vcount[10:0], hblnk, vblnk, hsync, vsync.
REQ-008 map_addr  output  ADDR_W  read address into the map RAM, row-major: row*MAP_W + col.
REQ-009 map_data  input  tile (snake_pkg)  map RAM read data, valid exactly 1 cycle after map_addr.
REQ-010 act_tile  output  tile  tile under the current output pixel; feeds draw_game.
REQ-011 vga_out  vga_if.out  -  vga_in delayed to align with act_tile.

Function
REQ-012 Total latency vga_in -> {vga_out, act_tile} SHALL be exactly 2 cycles: stage 1 registers map_addr and timing, stage 2 registers map_data and timing.
REQ-013 Block SHALL NOT use division or multiplication; tile position SHALL come from counters.
REQ-014 Counters: px_x (0..TILE_SIZE-1), col (0..MAP_W-1), px_y (0..TILE_SIZE-1), row (0..MAP_H-1), row_base (row*MAP_W, accumulated).
REQ-015 When vga_in.hcount == 0: px_x <= 0, col <= 0 (start of line).
REQ-016 Each cycle with hcount != 0 and hcount < MAP_W*TILE_SIZE: px_x increments; on px_x == TILE_SIZE-1, px_x <= 0 and col increments.
REQ-017 col SHALL saturate at MAP_W-1; it SHALL NOT wrap within a line.
REQ-018 Line advance occurs once per line on the cycle hcount == MAP_W*TILE_SIZE (end of active line).
REQ-019 On line advance with vcount < MAP_H*TILE_SIZE: px_y increments; on px_y == TILE_SIZE-1, px_y <= 0, row increments, row_base <= row_base + MAP_W.
REQ-020 When vga_in.vcount == 0 and hcount == 0: px_y, row, row_base SHALL clear to 0 (frame restart has priority over line advance).
REQ-021 map_addr SHALL be registered as row_base + col_current, where col_current is the column for the pixel at vga_in this cycle (hcount==0 -> column 0).
REQ-022 Active region: hcount < MAP_W*TILE_SIZE and vcount < MAP_H*TILE_SIZE; flag SHALL be piped alongside map_addr.
REQ-023 act_tile SHALL equal map_data when the piped active flag is 1, else EMPTY.
REQ-024 Out-of-range vcount (>= MAP_H*TILE_SIZE, i.e. vertical blank) SHALL hold row at MAP_H-1 and SHALL NOT advance row_base.
REQ-025 hsync/vsync/hblnk/vblnk/hcount/vcount SHALL pass unchanged in value, delayed exactly 2 cycles.

Reset
REQ-026 While rst == 0: map_addr = 0, act_tile = EMPTY, all vga_out fields = 0, all counters and pipeline registers = 0.
REQ-027 Reset asserted mid-frame SHALL clear state asynchronously; after release, counters SHALL resynchronise at the next hcount == 0 / vcount == 0 without further intervention.
REQ-028 First 2 cycles after release SHALL output act_tile = EMPTY regardless of map_data.

Verification
REQ-029 Frame start: vcount=0, hcount=0..47 -> map_addr 0,0..(x16),1..,2; act_tile trails map_addr by one cycle, vga_out.hcount trails vga_in by 2.
REQ-030 Tile boundary: vcount=16, hcount=16 -> map_addr = 41; vcount=479, hcount=639 -> map_addr = 1199.
REQ-031 Map RAM model with tile[5] = WALL, all else EMPTY -> act_tile = WALL for pixels hcount 80..95, vcount 0..15 only, aligned with vga_out.hcount 80..95.
REQ-032 Blanking: hcount=700 or vcount=500 with map_data = SNAKE1 -> act_tile = EMPTY; sync outputs equal inputs delayed 2.
REQ-033 Reset pulse at vcount=200, hcount=300 -> outputs 0/EMPTY immediately; next frame map_addr sequence identical to REQ-029.
REQ-034 Two consecutive frames: map_addr sequence of frame 2 identical to frame 1 (no row_base drift).
